// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch stage, one outstanding imem request, one-entry skid buffer.
// Define IF_PERF_CNT_EN to add saturating fetch_cnt_o / bubble_cnt_o counters.
module if_fetch_unit #(
    parameter int unsigned        IMEM_AW  = 32,
    parameter logic [IMEM_AW-1:0] PC_RESET = '0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [IMEM_AW-1:0] redirect_pc_i,
    output logic               imem_req_o,
    output logic [IMEM_AW-1:0] imem_addr_o,
    input  logic               imem_ack_i,
    input  logic [31:0]        imem_data_i,
    output logic [IMEM_AW-1:0] pc_o,
    output logic [31:0]        instruction_o,
    output logic               valid_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]        fetch_cnt_o,
    output logic [31:0]        bubble_cnt_o
`endif
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_PEND, S_DROP} state_t;

    state_t             r_state, w_state_n;
    logic [IMEM_AW-1:0] r_pc, w_pc_n;
    logic [IMEM_AW-1:0] r_addr, w_addr_n;
    logic [IMEM_AW-1:0] r_pc_out, w_pc_out_n;
    logic [IMEM_AW-1:0] r_skid_pc, w_skid_pc_n;
    logic [31:0]        r_instr, w_instr_n;
    logic [31:0]        r_skid_data, w_skid_data_n;
    logic               r_valid, w_valid_n;
    logic [IMEM_AW-1:0] w_pc_inc, w_redir_pc;
    logic               w_redir_drop;

    assign w_pc_inc   = r_pc + IMEM_AW'(4);
    assign w_redir_pc = redirect_pc_i & ~IMEM_AW'(3);
    // A redirect cannot cancel a request still in flight; it must be drained first
    assign w_redir_drop = (r_state == S_DROP) || (r_state == S_REQ && !imem_ack_i);

    always_comb begin
        w_state_n     = r_state;
        w_pc_n        = r_pc;
        w_addr_n      = r_addr;
        w_pc_out_n    = r_pc_out;
        w_instr_n     = r_instr;
        w_valid_n     = r_valid;
        w_skid_pc_n   = r_skid_pc;
        w_skid_data_n = r_skid_data;
        case (r_state)
            S_IDLE: begin
                w_state_n = S_REQ;
                w_addr_n  = r_pc;
            end
            S_REQ: begin
                if (imem_ack_i) begin
                    w_pc_n = w_pc_inc;
                    if (stall_i) begin
                        w_skid_pc_n   = r_pc;
                        w_skid_data_n = imem_data_i;
                        w_state_n     = S_PEND;
                    end else begin
                        w_pc_out_n = r_pc;
                        w_instr_n  = imem_data_i;
                        w_valid_n  = 1'b1;
                        w_addr_n   = w_pc_inc;
                    end
                end else if (!stall_i) begin
                    w_valid_n = 1'b0;
                end
            end
            S_PEND: begin
                if (!stall_i) begin
                    w_pc_out_n = r_skid_pc;
                    w_instr_n  = r_skid_data;
                    w_valid_n  = 1'b1;
                    w_state_n  = S_REQ;
                    w_addr_n   = r_pc;
                end
            end
            S_DROP: begin
                if (imem_ack_i) begin
                    w_state_n = S_REQ;
                    w_addr_n  = r_pc;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
        if (redirect_i) begin
            w_pc_n        = w_redir_pc;
            w_valid_n     = 1'b0;
            w_pc_out_n    = r_pc_out;
            w_instr_n     = r_instr;
            w_skid_pc_n   = '0;
            w_skid_data_n = '0;
            w_state_n     = w_redir_drop ? S_DROP : S_REQ;
            w_addr_n      = w_redir_drop ? r_addr : w_redir_pc;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= S_IDLE;
            r_pc        <= PC_RESET;
            r_addr      <= '0;
            r_pc_out    <= '0;
            r_instr     <= '0;
            r_valid     <= 1'b0;
            r_skid_pc   <= '0;
            r_skid_data <= '0;
        end else begin
            r_state     <= w_state_n;
            r_pc        <= w_pc_n;
            r_addr      <= w_addr_n;
            r_pc_out    <= w_pc_out_n;
            r_instr     <= w_instr_n;
            r_valid     <= w_valid_n;
            r_skid_pc   <= w_skid_pc_n;
            r_skid_data <= w_skid_data_n;
        end
    end

    assign imem_req_o    = (r_state == S_REQ) || (r_state == S_DROP);
    assign imem_addr_o   = r_addr;
    assign pc_o          = r_pc_out;
    assign instruction_o = r_instr;
    assign valid_o       = r_valid;

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_fetch_cnt, r_bubble_cnt;
    logic        w_fetch, w_bubble;

    // Valid is only ever loaded high with stall low; a stalled valid is a hold
    assign w_fetch  = w_valid_n && !stall_i;
    assign w_bubble = !r_valid && !stall_i && (r_state != S_IDLE);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_fetch_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_fetch && r_fetch_cnt != '1)
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            if (w_bubble && r_bubble_cnt != '1)
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign fetch_cnt_o  = r_fetch_cnt;
    assign bubble_cnt_o = r_bubble_cnt;
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: random-latency imem model, PC-stream scoreboard and output-hold monitor.
module tb_if_fetch_unit;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_data_i = '0;
    logic [31:0] pc_o;
    logic [31:0] instruction_o;
    logic        valid_o;

    int checks = 0;
    int failures = 0;
    int pops = 0;
    int lat_mode = 0;

    logic [31:0] exp_pc [0:4095];
    int          wr_idx = 0;
    int          seg_start = 0;
    int          mon_idx = 0;
    logic [31:0] gen_pc = '0;

    if_fetch_unit dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
        .pc_o(pc_o), .instruction_o(instruction_o), .valid_o(valid_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Start a fresh expected PC stream; older entries are flushed
    task automatic restart(input logic [31:0] pc);
        seg_start = wr_idx;
        gen_pc = {pc[31:2], 2'b00};
    endtask

    task automatic cycle(input logic st, input logic rd, input logic [31:0] tgt);
        stall_i = st;
        redirect_i = rd;
        redirect_pc_i = tgt;
        @(posedge clk_i);
        #2;
        if (rd) restart(tgt);
        if (wr_idx < 4096) begin
            exp_pc[wr_idx] = gen_pc;
            wr_idx++;
        end
        gen_pc = gen_pc + 32'd4;
    endtask

    // Memory model (drives at +1 after each edge) and output monitor (at negedge)
    initial begin
        logic        busy, acked, fresh, stall_s, redir_s, had_prev;
        logic [31:0] addr_q, prev_pc, prev_instr;
        logic        prev_valid;
        int          wl;
        busy = 0; acked = 0; had_prev = 0; addr_q = '0; wl = 0;
        prev_pc = '0; prev_instr = '0; prev_valid = 0;
        forever begin
            @(posedge clk_i);
            stall_s = stall_i;
            redir_s = redirect_i;
            #1;
            if (!rst_i) begin
                busy = 0;
                acked = 0;
                imem_ack_i = 0;
            end else begin
                fresh = 0;
                if (acked) busy = 0;
                if (imem_req_o && !busy) begin
                    busy = 1;
                    fresh = 1;
                    addr_q = imem_addr_o;
                    wl = (lat_mode >= 0) ? lat_mode : int'($urandom_range(0, 3));
                    chk("addr_aligned", {30'd0, imem_addr_o[1:0]}, 32'd0);
                end
                if (busy && !fresh) begin
                    chk("addr_stable", imem_addr_o, addr_q);
                    chk("req_held", 32'(imem_req_o), 32'd1);
                end
                if (busy) begin
                    if (wl == 0) begin
                        imem_ack_i = 1;
                        imem_data_i = addr_q ^ KEY;
                    end else begin
                        wl--;
                        imem_ack_i = 0;
                        imem_data_i = $urandom;
                    end
                end else begin
                    imem_ack_i = ($urandom_range(0, 3) == 0);
                    imem_data_i = $urandom;
                end
                acked = imem_ack_i && busy;
            end
            @(negedge clk_i);
            if (!rst_i) begin
                had_prev = 0;
            end else begin
                if (had_prev && stall_s && !redir_s) begin
                    chk("hold_pc", pc_o, prev_pc);
                    chk("hold_instr", instruction_o, prev_instr);
                    chk("hold_valid", 32'(valid_o), 32'(prev_valid));
                end else if (!stall_s && valid_o) begin
                    if (mon_idx < seg_start) mon_idx = seg_start;
                    if (mon_idx >= wr_idx) begin
                        checks++;
                        failures++;
                        $display("FAIL sb_empty actual_pc=%h expected=none", pc_o);
                    end else begin
                        chk("sb_pc", pc_o, exp_pc[mon_idx]);
                        chk("sb_instr", instruction_o, exp_pc[mon_idx] ^ KEY);
                        mon_idx++;
                        pops++;
                    end
                end
                prev_pc = pc_o;
                prev_instr = instruction_o;
                prev_valid = valid_o;
                had_prev = 1;
            end
        end
    end

    initial begin
        int cnt;
        bit found;
        repeat (3) @(posedge clk_i);
        #2;
        chk("rst_req", 32'(imem_req_o), 32'd0);
        chk("rst_addr", imem_addr_o, 32'd0);
        chk("rst_pc", pc_o, 32'd0);
        chk("rst_instr", instruction_o, 32'd0);
        chk("rst_valid", 32'(valid_o), 32'd0);
        rst_i = 1;
        restart(32'd0);

        // zero-wait streaming
        lat_mode = 0;
        for (int k = 1; k <= 20; k++) begin
            cycle(0, 0, $urandom);
            if (k >= 3) chk("p1_valid", 32'(valid_o), 32'd1);
        end

        // stall 4 cycles during back-to-back fetch
        for (int k = 1; k <= 4; k++) begin
            cycle(1, 0, $urandom);
            if (k == 2) chk("skid_req_low", 32'(imem_req_o), 32'd0);
        end
        repeat (10) cycle(0, 0, $urandom);

        // fixed 3-cycle ack latency
        lat_mode = 2;
        repeat (9) cycle(0, 0, $urandom);
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            cycle(0, 0, $urandom);
            if (valid_o) cnt++;
        end
        chk("lat3_valid_count", cnt, 32'd10);

        // redirect while a request is outstanding
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (imem_req_o && !imem_ack_i) found = 1;
            else cycle(0, 0, $urandom);
        end
        chk("p4_outstanding", 32'(found), 32'd1);
        cycle(0, 1, 32'h0000_0103);
        chk("drop_valid", 32'(valid_o), 32'd0);
        chk("drop_req", 32'(imem_req_o), 32'd1);
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (valid_o) found = 1;
            else cycle(0, 0, $urandom);
        end
        chk("drop_first_pc", found ? pc_o : 32'hDEAD_BEEF, 32'h0000_0100);
        repeat (6) cycle(0, 0, $urandom);

        // PC wrap at 2^32
        lat_mode = 0;
        cycle(0, 1, 32'hFFFF_FFF8);
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            cycle(0, 0, $urandom);
            if (imem_addr_o == 32'd0) found = 1;
        end
        chk("wrap_addr_zero", 32'(found), 32'd1);
        repeat (5) cycle(0, 0, $urandom);

        // redirect and stall together
        cycle(1, 1, 32'h0000_0200);
        chk("redir_stall_valid", 32'(valid_o), 32'd0);
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            cycle(0, 0, $urandom);
            if (valid_o) found = 1;
        end
        chk("redir_stall_pc", found ? pc_o : 32'hDEAD_BEEF, 32'h0000_0200);

        // random stalls, redirects and latencies
        lat_mode = -1;
        for (int k = 0; k < 400; k++)
            cycle(($urandom_range(0, 9) < 3), ($urandom_range(0, 29) == 0), $urandom);

        // reset mid-transaction
        cycle(0, 0, $urandom);
        rst_i = 0;
        #1;
        chk("midrst_req", 32'(imem_req_o), 32'd0);
        chk("midrst_addr", imem_addr_o, 32'd0);
        chk("midrst_pc", pc_o, 32'd0);
        chk("midrst_valid", 32'(valid_o), 32'd0);
        repeat (2) @(posedge clk_i);
        #2;
        stall_i = 0;
        redirect_i = 0;
        rst_i = 1;
        restart(32'd0);
        lat_mode = 0;
        repeat (10) cycle(0, 0, $urandom);
        chk("post_rst_valid", 32'(valid_o), 32'd1);

        chk("deliveries", 32'(pops > 100), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage. Holds the PC, issues word fetches to instruction memory over a req/ack handshake, and presents {pc, instruction, valid} to the IF/ID pipeline register. It absorbs stall requests from the hazard unit and PC redirects from branch/jump resolution. At most one memory request is outstanding, and there is a one-entry skid buffer.

Parameters:
PC_RESET, 32'h0000_0000, PC fetched first after reset
IMEM_AW, 32, width of imem_addr_o, pc_o, redirect_pc_i

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous, active-low reset
stall_i  input  1  hazard unit: downstream holds; outputs must not change
redirect_i  input  1  taken branch/jump: flush and refetch
redirect_pc_i  input  IMEM_AW  redirect target
imem_req_o  output  1  fetch request
imem_addr_o  output  IMEM_AW  fetch address, word aligned
imem_ack_i  input  1  memory has returned data this cycle
imem_data_i  input  32  instruction word, valid when imem_ack_i=1
pc_o  output  IMEM_AW  PC of instruction_o
instruction_o  output  32  fetched instruction
valid_o  output  1  instruction_o is a real instruction, not a bubble

Behaviour:
- Reset (rst_i=0, async): state=IDLE; pc_r=PC_RESET; imem_req_o=0; imem_addr_o=0; pc_o=0; instruction_o=0; valid_o=0; skid buffer empty.
- Handshake: while imem_req_o=1, imem_addr_o holds stable until imem_ack_i=1 is sampled at a posedge. Ack is ignored when req=0. Minimum ack latency is 1 cycle after req rises. Back-to-back requests are allowed: req stays high and the address advances on the same edge as the ack.
- IDLE: lasts exactly 1 cycle after reset release, then goes to REQ with imem_addr_o=pc_r.
- REQ, ack, stall_i=0: {pc_o, instruction_o, valid_o} <= {pc_r, imem_data_i, 1}; pc_r += 4; stay in REQ with addr=pc_r+4. Throughput: 1 instruction/cycle with a zero-wait memory.
- REQ, ack, stall_i=1: skid <= {pc_r, imem_data_i}; pc_r += 4; go to PEND; req=0. Outputs are held.
- REQ, no ack: stall_i=0 gives valid_o <= 0 (bubble). stall_i=1 holds all outputs.
- PEND: req=0. When stall_i=0, outputs <= {skid, valid=1} and the unit goes to REQ with addr=pc_r.
- Redirect has the highest priority and overrides stall_i:
  - pc_r <= {redirect_pc_i[IMEM_AW-1:2], 2'b00}; valid_o <= 0; skid cleared. pc_o and instruction_o keep their old values.
  - In REQ without ack: go to DROP. The request stays high at the old address.
  - In REQ with ack, or in PEND/IDLE: the response is discarded; go to REQ with addr = new pc_r.
  - In DROP: pc_r updates; stay in DROP.
- DROP: wait for ack, discard the data, then go to REQ with addr=pc_r. No output update.
- PC arithmetic is modulo 2^IMEM_AW: 32'hFFFF_FFFC + 4 wraps to 0.
- Reset asserted mid-transaction: all state returns to reset values immediately. A pending memory response is the memory's responsibility and is ignored because req=0.

Optional Feature:
IF_PERF_CNT_EN
- Defined: adds outputs fetch_cnt_o[31:0] and bubble_cnt_o[31:0], both reset to 0 and saturating at 32'hFFFF_FFFF.
  - fetch_cnt_o increments on each output load with valid=1.
  - bubble_cnt_o increments on each cycle with valid_o=0 and stall_i=0 (excluding IDLE).
- Undefined: the ports and the counter logic are absent.

Test Plan:
- Reset release, PC_RESET=0, ack every cycle, data=pc^32'hA5A5_0000 -> pc_o sequence 0,4,8,... with valid_o=1 every cycle from the 3rd posedge on; instruction_o matches.
- Ack latency 3 cycles -> imem_addr_o stable for 3 cycles per fetch; valid_o pattern 1,0,0 per instruction.
- stall_i=1 for 4 cycles during back-to-back fetch -> outputs frozen; exactly one word enters the skid buffer; on release, skid PC delivered first, then PC+4, with no instruction lost or duplicated.
- redirect_i with redirect_pc_i=32'h0000_0103 while a request is outstanding -> DROP; stale ack data never appears; next valid pc_o=32'h0000_0100.
- pc_r=32'hFFFF_FFFC, ack -> next imem_addr_o=0.
- redirect_i and stall_i both high in the same cycle -> valid_o=0 next cycle; the redirect target is fetched next.
